zero_ram_responder: RTL and testbench

- Memory-side responder for the core's Ram* interface. It takes the read and write requests that zerocore drives out and serves them from an on-chip 64-bit word array.
- After reset, an init state machine zero-fills the array. Reads return data after a parameterised pipeline latency. Writes are merged under a per-bit mask.
- Sits between zerocore and the simulation top, replacing the external virtual RAM in local tests.

---
 rtl/zero_ram_responder.sv | 112 +++++++++++
 tb/tb_zero_ram_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_ram_responder.sv
// On-chip 64-bit word RAM serving the core's Ram* interface: zero-filled after reset,
// masked writes, write-first reads through a READ_LAT-deep registered pipeline.
module zero_ram_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RamReadEnable,
    input  logic [63:0] RamReadAddr,
    input  logic        RamWriteEnable,
    input  logic [63:0] RamWriteAddr,
    input  logic [63:0] RamWriteMask,
    input  logic [63:0] RamWriteData,
    output logic [63:0] RamReadData,
    output logic        ram_rvalid,
    output logic        ram_ready,
    output logic        ram_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [63:0] SpanBytes = 64'(DEPTH) << 3;

    typedef enum logic [0:0] {StInit, StServe} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            err_q;
    logic [READ_LAT-1:0] pv_q;
    logic [63:0]     pd_q [READ_LAT];
    logic [63:0]     mem  [DEPTH];

    logic [63:0]     woff, roff;
    logic            win, rin;
    logic [AW-1:0]   widx, ridx;
    logic            serve, wr_hit, rd_req;
    logic [63:0]     merged, rdata_d;

    always_comb begin
        woff    = RamWriteAddr - BASE_ADDR;
        roff    = RamReadAddr - BASE_ADDR;
        win     = woff < SpanBytes;
        rin     = roff < SpanBytes;
        widx    = woff[3 +: AW];
        ridx    = roff[3 +: AW];
        serve   = (state_q == StServe);
        wr_hit  = serve && RamWriteEnable && win;
        rd_req  = serve && RamReadEnable;
        merged  = (mem[widx] & ~RamWriteMask) | (RamWriteData & RamWriteMask);
        // Write-first: a same-word read sees the merged value of this cycle's write.
        if (!rin) begin
            rdata_d = '0;
        end else if (wr_hit && (widx == ridx)) begin
            rdata_d = merged;
        end else begin
            rdata_d = mem[ridx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pv_q    <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= StServe;
                    end
                end
                StServe: begin
                    if ((RamReadEnable && !rin) || (RamWriteEnable && !win)) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= StInit;
            endcase
            // Data registers only load behind a valid so the output holds between responses.
            pv_q[0] <= rd_req;
            if (rd_req) begin
                pd_q[0] <= rdata_d;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[cnt_q] <= '0;
        end else if (wr_hit) begin
            mem[widx] <= merged;
        end
    end

    assign RamReadData = pd_q[READ_LAT-1];
    assign ram_rvalid  = pv_q[READ_LAT-1];
    assign ram_ready   = serve;
    assign ram_err     = err_q;

endmodule

// File: tb/tb_zero_ram_responder.sv
// Bench for zero_ram_responder: READ_LAT=1 and READ_LAT=3 instances share stimulus; a
// reference word model feeds per-instance scoreboards checked on every response.
module tb_zero_ram_responder;

    localparam logic [63:0] Base  = 64'h0000_0000_8000_0000;
    localparam int unsigned Depth = 1024;

    typedef struct packed {
        logic [63:0] data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0;
    logic [63:0] ra = '0, wa = '0, wm = '0, wd = '0;
    logic [63:0] rd1, rd3;
    logic        rv1, rv3, rdy1, rdy3, err1, err3;

    int unsigned ecount = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q1[$];
    exp_t        q3[$];
    logic [63:0] model [Depth];
    logic        err_m = 1'b0;

    zero_ram_responder #(.BASE_ADDR(Base), .DEPTH(Depth), .READ_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .RamReadEnable(re), .RamReadAddr(ra),
        .RamWriteEnable(we), .RamWriteAddr(wa), .RamWriteMask(wm), .RamWriteData(wd),
        .RamReadData(rd1), .ram_rvalid(rv1), .ram_ready(rdy1), .ram_err(err1)
    );

    zero_ram_responder #(.BASE_ADDR(Base), .DEPTH(Depth), .READ_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .RamReadEnable(re), .RamReadAddr(ra),
        .RamWriteEnable(we), .RamWriteAddr(wa), .RamWriteMask(wm), .RamWriteData(wd),
        .RamReadData(rd3), .ram_rvalid(rv3), .ram_ready(rdy3), .ram_err(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    function automatic logic in_rng(input logic [63:0] a);
        logic [63:0] off;
        off = a - Base;
        return off < 64'(Depth * 8);
    endfunction

    function automatic logic [9:0] word_of(input logic [63:0] a);
        logic [63:0] off;
        off = a - Base;
        return off[12:3];
    endfunction

    task automatic mon_step(input string tag, input logic rv, input logic [63:0] rdat,
                            input int has, input exp_t front, output bit pop);
        pop = 1'b0;
        if (has == 0) begin
            check_eq({tag, "_spurious_rvalid"}, 64'(rv), 64'd0);
        end else if (ecount >= front.due) begin
            check_eq({tag, "_rvalid_latency"}, 64'(rv), 64'd1);
            if (rv) check_eq({tag, "_rdata"}, rdat, front.data);
            pop = 1'b1;
        end else begin
            check_eq({tag, "_early_rvalid"}, 64'(rv), 64'd0);
        end
    endtask

    always @(posedge clk) begin
        bit   pop;
        exp_t f;
        #1;
        f = (q1.size() != 0) ? q1[0] : '0;
        mon_step("l1", rv1, rd1, q1.size(), f, pop);
        if (pop) void'(q1.pop_front());
        f = (q3.size() != 0) ? q3[0] : '0;
        mon_step("l3", rv3, rd3, q3.size(), f, pop);
        if (pop) void'(q3.pop_front());
    end

    // Drives one request cycle and updates the model write-first, as the RAM does.
    task automatic do_op(input logic r, input logic [63:0] radr, input logic w,
                         input logic [63:0] wadr, input logic [63:0] mask,
                         input logic [63:0] data);
        logic [63:0] v;
        @(negedge clk);
        re = r; ra = radr; we = w; wa = wadr; wm = mask; wd = data;
        if (w) begin
            if (in_rng(wadr)) model[word_of(wadr)] = (model[word_of(wadr)] & ~mask) | (data & mask);
            else err_m = 1'b1;
        end
        if (r) begin
            v = in_rng(radr) ? model[word_of(radr)] : 64'd0;
            if (!in_rng(radr)) err_m = 1'b1;
            q1.push_back(exp_t'{data: v, due: ecount + 1});
            q3.push_back(exp_t'{data: v, due: ecount + 3});
        end
    endtask

    task automatic rd(input logic [63:0] a);
        do_op(1'b1, a, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] m, input logic [63:0] d);
        do_op(1'b0, '0, 1'b1, a, m, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            re = 1'b0; we = 1'b0;
            ra = $urandom(); wa = $urandom(); wd = $urandom(); wm = '1;
        end
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_err_l1"}, 64'(err1), 64'(err_m));
        check_eq({tag, "_err_l3"}, 64'(err3), 64'(err_m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; re = 1'b0; we = 1'b0;
        q1.delete();
        q3.delete();
        err_m = 1'b0;
        for (int i = 0; i < Depth; i++) model[i] = '0;
    endtask

    // Releases reset, holds a read at BASE through INIT and counts edges until ready.
    task automatic release_and_wait(input string tag);
        int n = 0;
        @(negedge clk);
        rst = 1'b1; re = 1'b1; ra = Base;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (rdy1) break;
        end
        check_eq({tag, "_ready_cycles"}, 64'(n), 64'(Depth));
        check_eq({tag, "_ready_l3"}, 64'(rdy3), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) model[i] = '0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_rdata_l1", rd1, 64'd0);
        check_eq("rst_rvalid_l3", 64'(rv3), 64'd0);
        check_eq("rst_ready_l1", 64'(rdy1), 64'd0);
        check_eq("rst_err_l3", 64'(err3), 64'd0);
        repeat (2) @(negedge clk);

        release_and_wait("init");
        rd(Base);
        idle(4);

        wr(64'h8000_0010, '1, 64'hDEAD_BEEF_0123_4567);
        rd(64'h8000_0010);
        rd(64'h8000_0017);
        idle(4);

        wr(64'h8000_0030, '1, '1);
        wr(64'h8000_0030, 64'h0000_0000_FFFF_0000, 64'd0);
        rd(64'h8000_0030);
        wr(64'h8000_0030, 64'd0, 64'h1234_5678_9ABC_DEF0);
        rd(64'h8000_0030);
        idle(4);

        wr(64'h8000_0020, '1, 64'hAA);
        do_op(1'b1, 64'h8000_0020, 1'b1, 64'h8000_0020, '1, 64'h55);
        do_op(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0040, 64'h0000_FFFF_0000_FFFF, 64'h77);
        rd(64'h8000_0010);
        rd(64'h8000_0020);
        rd(64'h8000_0030);
        rd(64'h8000_0040);
        idle(5);
        check_flags("inrange");

        wr(64'h7FFF_FFF8, '1, 64'h1111);
        idle(1);
        check_flags("err_low");
        wr(64'h8000_2000, '1, 64'h2222);
        rd(64'h8000_2000);
        rd(64'h8000_1FF8);
        rd(64'h8000_0000);
        idle(6);
        check_flags("err_persist");

        rd(64'h8000_0010);
        rd(64'h8000_0020);
        @(negedge clk);
        rst = 1'b0; re = 1'b0;
        #1;
        check_eq("midflight_rvalid_l3", 64'(rv3), 64'd0);
        check_eq("midflight_rdata_l3", rd3, 64'd0);
        check_eq("midflight_ready_l1", 64'(rdy1), 64'd0);
        check_eq("midflight_err_l1", 64'(err1), 64'd0);
        q1.delete();
        q3.delete();
        err_m = 1'b0;
        for (int i = 0; i < Depth; i++) model[i] = '0;
        repeat (2) @(negedge clk);

        rst = 1'b1;
        repeat (500) @(posedge clk);
        do_reset();
        #1;
        check_eq("midinit_ready_l3", 64'(rdy3), 64'd0);
        repeat (2) @(negedge clk);
        release_and_wait("reinit");
        rd(64'h8000_0010);
        rd(64'h8000_0020);
        rd(64'h8000_0040);
        idle(6);
        check_flags("final");
        check_eq("drain_q1", 64'(q1.size()), 64'd0);
        check_eq("drain_q3", 64'(q3.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
